dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the SDU debug channel (dbg_*) and the CPU (cpu_*).
//  Each requester uses a level req / one-cycle ack handshake. The block serialises the accesses and drives the
//  memory-side address, data and write enable, with a configurable synchronous read latency.
//  It sits between the SDU/CPU and the DM instance, replacing direct wiring of the DM address/din/we.
// PARAMETERS
//  AW        32  address width (word address as presented to DM)
//  DW        32  data width
//  RD_LAT    1   DM read latency in cycles (legal 1..4): mem_dout valid RD_LAT cycles after mem_addr is presented
//  DBG_PRIO  1   1: debug always wins a simultaneous request; 0: round-robin between the two ports
// PORTS
//  clk        in   1   system clock
//  rstn       in   1   asynchronous reset, active low
//  dbg_req    in   1   debug access request (level)
//  dbg_we     in   1   1 = write, 0 = read
//  dbg_addr   in   AW  debug address
//  dbg_wdata  in   DW  debug write data
//  dbg_ack    out  1   one-cycle completion pulse
//  dbg_rdata  out  DW  read data; valid from ack, held until next debug read completes
//  cpu_req / cpu_we / cpu_addr / cpu_wdata / cpu_ack / cpu_rdata: same widths and meaning, CPU port
//  mem_addr   out  AW  address to DM
//  mem_din    out  DW  write data to DM
//  mem_we     out  1   DM write enable
//  mem_dout   in   DW  DM read data
//  busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - state=IDLE; all outputs 0: acks, rdata, mem_addr, mem_din, mem_we, busy.
//   - RR pointer = "cpu served last", so debug wins the first tie.
//  Handshake:
//   - Requester holds req, we, addr and wdata stable until it sees ack.
//   - req is sampled only in IDLE. If req is still high in the cycle after ack, it is a new back-to-back request.
//  FSM states:
//   - IDLE: if any req, grant one port, latch owner/we/addr/wdata, go to ACCESS. Otherwise stay.
//   - ACCESS: mem_addr/mem_din = latched values, held for the whole state.
//     - Write: mem_we=1 for exactly this one cycle, then RESP.
//     - Read: mem_we=0; cnt counts 0..RD_LAT. At cnt==RD_LAT, capture mem_dout into the owner's rdata, then RESP.
//   - RESP: owner's ack=1 for one cycle; always go to IDLE. mem_we=0.
//  Latency (req high in IDLE at cycle 0):
//   - Write: ack at cycle 2.
//   - Read: ack at cycle 2+RD_LAT.
//   - One IDLE bubble between consecutive accesses.
//  Arbitration:
//   - DBG_PRIO=1: dbg beats cpu on a tie. CPU can starve under continuous debug traffic; this is accepted.
//   - DBG_PRIO=0: on a tie, grant the port not served last. The pointer updates on every grant, including uncontested ones.
//   - A request arriving while busy waits; no preemption.
//  Outputs and registers:
//   - mem_addr/mem_din keep their last values outside ACCESS (no glitch to 0).
//   - The non-owner's ack stays 0 and its rdata is unchanged.
//  Boundaries:
//   - Address is passed through unmodified; there is no wrap or range check.
//   - A write never alters either rdata register.
//   - Reset mid-ACCESS: mem_we drops immediately, no ack is issued, rdata is cleared; the requester must re-request.
//   - Dropping req before ack is illegal. The access still completes and acks anyway.
// TESTING
//  1 Reset: rstn=0 mid-read -> all outputs 0 immediately, no ack after release, busy=0.
//  2 Debug write then read:
//    - dbg write addr=0x10 data=0xDEADBEEF -> mem_we high exactly 1 cycle, dbg_ack at cycle 2.
//    - dbg read 0x10 (RD_LAT=1) -> dbg_ack at cycle 3, dbg_rdata=0xDEADBEEF.
//  3 Tie, DBG_PRIO=1: both req in same cycle -> dbg served first, cpu acked after; cpu_rdata untouched by dbg op.
//  4 Tie, DBG_PRIO=0: ties on three consecutive requests -> grants alternate dbg, cpu, dbg.
//  5 RD_LAT=3: cpu read 0x20 holding 0x12345678 -> cpu_ack at cycle 5 with data; mem_addr stable 4 cycles.
//  6 Back-to-back: cpu holds req after ack -> second access acked 1 bubble later; debug req arriving mid-access waits, no preempt.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the SDU debug channel and the CPU.
// Accesses are serialised IDLE -> ACCESS -> RESP with a configurable synchronous read latency.
module dm_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter bit DBG_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int            CW       = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;          // 1 = CPU owns the current access
    logic          last_cpu_q, last_cpu_d;    // round-robin pointer: 1 = CPU served last
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;

    logic any_req;
    logic grant_cpu;

    assign any_req   = dbg_req || cpu_req;
    assign grant_cpu = cpu_req && (!dbg_req || (!DBG_PRIO && !last_cpu_q));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (we_q || (cnt_q == CNT_LAST)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we  = 1'b0;
        dbg_ack = 1'b0;
        cpu_ack = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            ACCESS:  mem_we = we_q;
            RESP: begin
                dbg_ack = !owner_q;
                cpu_ack = owner_q;
            end
            default: ;
        endcase
    end

    // Request is latched at grant; the read counter runs 0..RD_LAT and the
    // memory data is captured into the owner's register on the last count.
    always_comb begin
        owner_d     = owner_q;
        last_cpu_d  = last_cpu_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d    = grant_cpu;
                    last_cpu_d = grant_cpu;
                    we_d       = grant_cpu ? cpu_we    : dbg_we;
                    addr_d     = grant_cpu ? cpu_addr  : dbg_addr;
                    wdata_d    = grant_cpu ? cpu_wdata : dbg_wdata;
                    cnt_d      = '0;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (cnt_q == CNT_LAST) begin
                        if (owner_q) cpu_rdata_d = mem_dout;
                        else         dbg_rdata_d = mem_dout;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q     <= 1'b0;
            last_cpu_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            dbg_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            last_cpu_q  <= last_cpu_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_din   = wdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: instance A (RD_LAT=1, debug priority) and
// instance B (RD_LAT=3, round-robin), each with a small behavioural data memory.
module tb_dm_port_arbiter;

    typedef struct {
        bit          cpu;
        int          cyc;
        logic [31:0] dbg_rd;
        logic [31:0] cpu_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic        a_dbg_req, a_dbg_we, a_dbg_ack, a_cpu_req, a_cpu_we, a_cpu_ack, a_mem_we, a_busy;
    logic [31:0] a_dbg_addr, a_dbg_wdata, a_dbg_rdata, a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic [31:0] a_mem_addr, a_mem_din, a_mem_dout;
    logic        b_dbg_req, b_dbg_we, b_dbg_ack, b_cpu_req, b_cpu_we, b_cpu_ack, b_mem_we, b_busy;
    logic [31:0] b_dbg_addr, b_dbg_wdata, b_dbg_rdata, b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;
    bit          a_dbg_hold, a_cpu_hold, b_dbg_hold, b_cpu_hold;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] b_p1, b_p2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .DBG_PRIO(1'b1)) u_dut_a (
        .clk(clk), .rstn(rstn),
        .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
        .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_we(a_mem_we), .mem_dout(a_mem_dout),
        .busy(a_busy)
    );

    dm_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .DBG_PRIO(1'b0)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_we(b_mem_we), .mem_dout(b_mem_dout),
        .busy(b_busy)
    );

    // Data memories: A returns data one cycle after the address, B three cycles after.
    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_din;
        a_mem_dout <= mem_a[a_mem_addr[7:0]];
        if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_din;
        b_p1       <= mem_b[b_mem_addr[7:0]];
        b_p2       <= b_p1;
        b_mem_dout <= b_p2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops the oldest expected response of that instance.
    always @(negedge clk) begin
        if (a_dbg_ack || a_cpu_ack) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_ack", {62'd0, a_cpu_ack, a_dbg_ack}, 64'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_ack_port", {62'd0, a_cpu_ack, a_dbg_ack}, ea.cpu ? 64'd2 : 64'd1);
                check("a_ack_cycle", cyc, ea.cyc);
                check("a_dbg_rdata", a_dbg_rdata, ea.dbg_rd);
                check("a_cpu_rdata", a_cpu_rdata, ea.cpu_rd);
            end
        end
        if (b_dbg_ack || b_cpu_ack) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_ack", {62'd0, b_cpu_ack, b_dbg_ack}, 64'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_ack_port", {62'd0, b_cpu_ack, b_dbg_ack}, eb.cpu ? 64'd2 : 64'd1);
                check("b_ack_cycle", cyc, eb.cyc);
                check("b_dbg_rdata", b_dbg_rdata, eb.dbg_rd);
                check("b_cpu_rdata", b_cpu_rdata, eb.cpu_rd);
            end
        end
    end

    task automatic push_a(input bit cpu, input int c, input logic [31:0] d, input logic [31:0] cr);
        exp_t e;
        e.cpu = cpu; e.cyc = c; e.dbg_rd = d; e.cpu_rd = cr;
        q_a.push_back(e);
    endtask

    task automatic push_b(input bit cpu, input int c, input logic [31:0] d, input logic [31:0] cr);
        exp_t e;
        e.cpu = cpu; e.cyc = c; e.dbg_rd = d; e.cpu_rd = cr;
        q_b.push_back(e);
    endtask

    // Advance n cycles; requesters without a hold flag drop req in their ack cycle.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (a_dbg_ack && !a_dbg_hold) a_dbg_req = 1'b0;
            if (a_cpu_ack && !a_cpu_hold) a_cpu_req = 1'b0;
            if (b_dbg_ack && !b_dbg_hold) b_dbg_req = 1'b0;
            if (b_cpu_ack && !b_cpu_hold) b_cpu_req = 1'b0;
            @(posedge clk);
        end
        #1;
    endtask

    task automatic a_issue(input bit cpu, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (cpu) begin
            a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata; a_cpu_req = 1'b1;
        end else begin
            a_dbg_we = we; a_dbg_addr = addr; a_dbg_wdata = wdata; a_dbg_req = 1'b1;
        end
    endtask

    task automatic b_issue(input bit cpu, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (cpu) begin
            b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata; b_cpu_req = 1'b1;
        end else begin
            b_dbg_we = we; b_dbg_addr = addr; b_dbg_wdata = wdata; b_dbg_req = 1'b1;
        end
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while ((a_dbg_req || a_cpu_req || a_busy) && n < 40) begin
            step(1);
            n++;
        end
        check("a_idle_timeout", {61'd0, a_dbg_req, a_cpu_req, a_busy}, 64'd0);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while ((b_dbg_req || b_cpu_req || b_busy) && n < 40) begin
            step(1);
            n++;
        end
        check("b_idle_timeout", {61'd0, b_dbg_req, b_cpu_req, b_busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        {a_dbg_req, a_dbg_we, a_cpu_req, a_cpu_we} = '0;
        {b_dbg_req, b_dbg_we, b_cpu_req, b_cpu_we} = '0;
        {a_dbg_addr, a_dbg_wdata, a_cpu_addr, a_cpu_wdata} = '0;
        {b_dbg_addr, b_dbg_wdata, b_cpu_addr, b_cpu_wdata} = '0;
        {a_dbg_hold, a_cpu_hold, b_dbg_hold, b_cpu_hold} = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        step(2);

        // Reset state
        check("rst_a_busy",  a_busy, 0);
        check("rst_a_memwe", a_mem_we, 0);
        check("rst_a_addr",  a_mem_addr, 0);
        check("rst_a_din",   a_mem_din, 0);
        check("rst_a_acks",  {a_dbg_ack, a_cpu_ack}, 0);
        check("rst_a_rdata", {a_dbg_rdata, a_cpu_rdata}, 0);
        check("rst_b_busy",  b_busy, 0);
        rstn = 1'b1;
        step(1);

        // Preload via CPU write on A, debug write on B
        c = cyc; a_issue(1, 1, 32'h30, 32'hCAFEF00D); push_a(1, c + 2, 32'h0, 32'h0);
        b_issue(0, 1, 32'h20, 32'h12345678);           push_b(0, c + 2, 32'h0, 32'h0);
        wait_idle_a();
        wait_idle_b();

        // Debug write: mem_we high exactly one cycle, ack at cycle 2
        c = cyc; a_issue(0, 1, 32'h10, 32'hDEADBEEF); push_a(0, c + 2, 32'h0, 32'h0);
        check("t2_we_c0", a_mem_we, 0);
        step(1);
        check("t2_we_c1",   a_mem_we, 1);
        check("t2_addr_c1", a_mem_addr, 32'h10);
        check("t2_din_c1",  a_mem_din, 32'hDEADBEEF);
        step(1);
        check("t2_we_c2", a_mem_we, 0);
        wait_idle_a();

        // Debug read back, ack at cycle 3
        c = cyc; a_issue(0, 0, 32'h10, 32'h0); push_a(0, c + 3, 32'hDEADBEEF, 32'h0);
        wait_idle_a();

        // Tie with debug priority: debug write first, then CPU reads the new value
        c = cyc;
        a_issue(0, 1, 32'h40, 32'h55AA55AA);
        a_issue(1, 0, 32'h40, 32'h0);
        push_a(0, c + 2, 32'hDEADBEEF, 32'h0);
        push_a(1, c + 6, 32'hDEADBEEF, 32'h55AA55AA);
        wait_idle_a();

        // Reset in the middle of a read
        c = cyc; a_issue(0, 0, 32'h10, 32'hFFFF0000);
        step(1);
        check("t1_busy_pre", a_busy, 1);
        check("t1_addr_pre", a_mem_addr, 32'h10);
        rstn = 1'b0;
        a_dbg_req = 1'b0;
        #1;
        check("t1_busy",  a_busy, 0);
        check("t1_memwe", a_mem_we, 0);
        check("t1_addr",  a_mem_addr, 0);
        check("t1_din",   a_mem_din, 0);
        check("t1_acks",  {a_dbg_ack, a_cpu_ack}, 0);
        check("t1_dbg_rdata", a_dbg_rdata, 0);
        check("t1_cpu_rdata", a_cpu_rdata, 0);
        step(2);
        rstn = 1'b1;
        step(6);
        check("t1_busy_post", a_busy, 0);

        // CPU back-to-back: second access acked four cycles after the first
        c = cyc; a_cpu_hold = 1'b1; a_issue(1, 0, 32'h40, 32'h0);
        push_a(1, c + 3, 32'h0, 32'h55AA55AA);
        push_a(1, c + 7, 32'h0, 32'h55AA55AA);
        step(4);
        a_cpu_hold = 1'b0;
        wait_idle_a();

        // Debug request arriving mid-access waits for the CPU access
        c = cyc; a_issue(1, 0, 32'h30, 32'h0); push_a(1, c + 3, 32'h0, 32'hCAFEF00D);
        step(1);
        a_issue(0, 0, 32'h10, 32'h0); push_a(0, c + 7, 32'hDEADBEEF, 32'hCAFEF00D);
        step(1);
        check("t6_no_preempt_addr", a_mem_addr, 32'h30);
        wait_idle_a();

        // RD_LAT=3 CPU read: address held four cycles, ack at cycle 5
        c = cyc; b_issue(1, 0, 32'h20, 32'h0); push_b(1, c + 5, 32'h0, 32'h12345678);
        step(1);
        for (int k = 0; k < 4; k++) begin
            check("t5_addr_stable", b_mem_addr, 32'h20);
            check("t5_we_low", b_mem_we, 0);
            step(1);
        end
        wait_idle_b();

        // Round-robin ties: dbg, cpu, dbg, then the remaining cpu request
        c = cyc; b_dbg_hold = 1'b1; b_cpu_hold = 1'b1;
        b_issue(0, 1, 32'h70, 32'hA0A0A0A0);
        b_issue(1, 1, 32'h71, 32'hB1B1B1B1);
        push_b(0, c + 2,  32'h0, 32'h12345678);
        push_b(1, c + 5,  32'h0, 32'h12345678);
        push_b(0, c + 8,  32'h0, 32'h12345678);
        push_b(1, c + 11, 32'h0, 32'h12345678);
        step(3);
        b_dbg_hold = 1'b0;
        step(3);
        b_cpu_hold = 1'b0;
        wait_idle_b();
        check("t4_mem70", mem_b[8'h70], 32'hA0A0A0A0);
        check("t4_mem71", mem_b[8'h71], 32'hB1B1B1B1);

        step(2);
        check("a_missing_acks", q_a.size(), 0);
        check("b_missing_acks", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
